roi_track_scheduler: RTL and testbench
======================================

Name: roi_track_scheduler

Overview:
- Time-multiplexes the single ROI tracker (ROI position register, accumulator update, in-ROI flags) across NUM_SLOTS tracked features.
- One slot is serviced per frame, in round-robin order.
- At each frame boundary the block loads the selected slot's coordinates into the tracker and arms its update. It then writes the refined position back into the slot table.
- Slots that miss updates repeatedly, or that drift outside the usable image area, are retired.

Parameters:
- NUM_SLOTS, 8, number of feature slots (power of 2).
- IDX_W, 3, slot index width, log2(NUM_SLOTS).
- NEIGH_SIZE, 10, ROI half-size in pixels; must match the tracker.
- BORDER_WIDTH, 2, extended-ROI border in pixels; must match the tracker.
- IMG_W, 1280, image width in pixels.
- IMG_H, 720, image height in pixels.
- MAX_MISS, 3, consecutive missed frames before a slot is retired.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  slot table write strobe.
- cfg_idx  in  IDX_W  slot to write.
- cfg_x  in  12  initial x (pixel, integer).
- cfg_y  in  11  initial y (pixel, integer).
- cfg_valid  in  1  1 = activate the slot, 0 = deactivate it.
- center_vsync_in  in  1  vertical sync, same signal the tracker sees; high = blanking.
- updated_in_this_frame  in  1  from tracker; tracker position has been updated this frame.
- x0_int  in  12  tracker's current rounded x.
- y0_int  in  11  tracker's current rounded y.
- set_x0  out  12  coordinate loaded into the tracker.
- set_y0  out  11  coordinate loaded into the tracker.
- reset_position  out  1  one-cycle load strobe to the tracker.
- enable  out  1  permits the tracker to update.
- cur_idx  out  IDX_W  slot currently in service.
- track_active  out  1  a slot is loaded and armed this frame.
- slot_lost  out  1  one-cycle pulse when a slot is retired.
- lost_idx  out  IDX_W  index of the retired slot, valid with slot_lost.
- frame_done  out  1  one-cycle pulse on a successful writeback.

Behaviour:
- Slot table: per slot x[11:0], y[10:0], valid, miss_cnt (enough bits to count to MAX_MISS).
- Reset values:
  - all table valid=0, miss_cnt=0;
  - all outputs 0; state IDLE;
  - last_idx = NUM_SLOTS-1, so the first search starts at slot 0;
  - vsync_q = 0.
- vsync_rise = center_vsync_in & ~vsync_q, where vsync_q is center_vsync_in registered.
- States:
  - IDLE: enable=0. On vsync_rise -> SELECT.
  - SELECT (1 cycle): circular search for the first valid slot from last_idx+1 (wrapping).
    - Found: cur_idx<=idx, last_idx<=idx -> LOAD.
    - None: -> IDLE, with track_active staying 0.
  - LOAD (1 cycle): reset_position=1; set_x0/set_y0 = table[cur_idx]; track_active<=1 -> ARM.
  - ARM: enable=1. Wait for center_vsync_in==0 -> TRACK.
    - A vsync_rise cannot occur while in ARM, since vsync is still high.
  - TRACK: enable=1.
    - updated_in_this_frame==1 -> WB.
    - Otherwise, vsync_rise -> MISS.
    - If both occur in the same cycle, WB wins.
  - WB (1 cycle):
    - table[cur_idx].x/y <= x0_int/y0_int; miss_cnt <= 0; frame_done=1; enable<=0; track_active<=0.
    - Bounds check on the new position. Out of bounds when x0_int < NEIGH_SIZE+BORDER_WIDTH+1, or x0_int > IMG_W-(NEIGH_SIZE+BORDER_WIDTH), or the same test for y with IMG_H.
    - Out of bounds: valid<=0, slot_lost=1, lost_idx=cur_idx.
    - -> IDLE.
  - MISS (1 cycle):
    - miss_cnt+1. If it reaches MAX_MISS: valid<=0, slot_lost=1, miss_cnt<=0. The stored coordinates are kept.
    - track_active<=0 -> SELECT directly, because this vsync_rise is the new frame boundary.
- set_x0/set_y0 hold their last value outside LOAD.
- cfg write:
  - Takes effect on the next clk edge: x, y, valid written, miss_cnt cleared.
  - Accepted in every state.
- Simultaneous cfg write and WB/MISS to the same slot: the cfg write wins, and the WB/MISS table update for that slot is suppressed. frame_done still pulses; slot_lost is suppressed.
- cfg write that deactivates cur_idx during ARM/TRACK: the FSM goes to IDLE on the next cycle with enable=0 and no writeback.
- rst mid-operation: everything returns to reset values on the next edge; no pulses are emitted.
- Width rule: bounds comparisons are done at 13 bits, so the subtraction of constants cannot wrap.

Test Plan:
- Reset, then cfg slot 2 = (700,500) valid, then a vsync high pulse.
  - -> SELECT picks 2; reset_position high for exactly 1 cycle with set_x0=700, set_y0=500; enable goes high.
- Tracker model returns x0_int=705, y0_int=498 and asserts updated mid-frame.
  - -> frame_done pulse; table[2]=(705,498); enable low before the next vsync.
- Slots 0, 3, 7 valid across 4 frames.
  - -> cur_idx sequence 0, 3, 7, 0 (wrap).
- Slot 1 valid and updated never asserted for 3 frames.
  - -> miss_cnt 1, 2, then slot_lost with lost_idx=1 at the third vsync_rise; the following frame finds no valid slot and track_active stays 0.
- Update lands at x0_int=12, with NEIGH_SIZE+BORDER_WIDTH+1=13.
  - -> slot_lost pulse and slot invalidated.
  - x0_int=13 -> no loss.
- cfg write to cur_idx coincident with WB, cfg=(100,100).
  - -> table holds (100,100) and miss_cnt=0.
- rst asserted during TRACK.
  - -> enable=0 next cycle and all slots invalid.

Source files
------------

// File: rtl/roi_track_scheduler_if.sv
// roi_track_scheduler_if: slot-table config bus and tracker link.
// master = config/tracker side, slave = roi_track_scheduler.
interface roi_track_scheduler_if #(
    parameter int IDX_W = 3
);
    // slot table configuration
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [11:0]      cfg_x;
    logic [10:0]      cfg_y;
    logic             cfg_valid;
    // tracker inputs
    logic             center_vsync_in;
    logic             updated_in_this_frame;
    logic [11:0]      x0_int;
    logic [10:0]      y0_int;
    // tracker control and status
    logic [11:0]      set_x0;
    logic [10:0]      set_y0;
    logic             reset_position;
    logic             enable;
    logic [IDX_W-1:0] cur_idx;
    logic             track_active;
    logic             slot_lost;
    logic [IDX_W-1:0] lost_idx;
    logic             frame_done;

    modport master (
        output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_valid,
        output center_vsync_in, updated_in_this_frame, x0_int, y0_int,
        input  set_x0, set_y0, reset_position, enable, cur_idx,
        input  track_active, slot_lost, lost_idx, frame_done
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_valid,
        input  center_vsync_in, updated_in_this_frame, x0_int, y0_int,
        output set_x0, set_y0, reset_position, enable, cur_idx,
        output track_active, slot_lost, lost_idx, frame_done
    );
endinterface

// File: rtl/roi_track_scheduler.sv
// roi_track_scheduler: shares one ROI tracker round-robin across slots.
// Ports: clk, rst (sync, active high), bus (cfg + tracker link, slave).
module roi_track_scheduler #(
    parameter int NUM_SLOTS    = 8,
    parameter int IDX_W        = 3,
    parameter int NEIGH_SIZE   = 10,
    parameter int BORDER_WIDTH = 2,
    parameter int IMG_W        = 1280,
    parameter int IMG_H        = 720,
    parameter int MAX_MISS     = 3
) (
    input logic                   clk,
    input logic                   rst,
    roi_track_scheduler_if.slave  bus
);
    localparam int MW     = $clog2(MAX_MISS + 1);
    localparam int MARGIN = NEIGH_SIZE + BORDER_WIDTH;
    // 13-bit limits so constant subtraction cannot wrap
    localparam logic [12:0] X_LO = 13'(MARGIN + 1);
    localparam logic [12:0] X_HI = 13'(IMG_W - MARGIN);
    localparam logic [12:0] Y_LO = 13'(MARGIN + 1);
    localparam logic [12:0] Y_HI = 13'(IMG_H - MARGIN);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_LOAD, S_ARM, S_TRACK, S_WB, S_MISS
    } state_e;

    state_e state_q, state_d;

    logic [11:0]          x_q    [NUM_SLOTS];
    logic [10:0]          y_q    [NUM_SLOTS];
    logic [MW-1:0]        miss_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid_q;

    logic [IDX_W-1:0] last_idx_q;
    logic [IDX_W-1:0] cur_idx_q;
    logic             vsync_q;
    logic             track_active_q;
    logic [11:0]      set_x0_q;
    logic [10:0]      set_y0_q;

    logic             vsync_rise;
    logic             cfg_hit;
    logic             cfg_kill;
    logic             found;
    logic [IDX_W-1:0] found_idx;
    logic [12:0]      nx13;
    logic [12:0]      ny13;
    logic             oob;
    logic [MW-1:0]    miss_inc;
    logic             miss_retire;

    assign vsync_rise = bus.center_vsync_in & ~vsync_q;
    // a cfg write to the serviced slot overrides any writeback/miss update
    assign cfg_hit    = bus.cfg_we && (bus.cfg_idx == cur_idx_q);
    assign cfg_kill   = cfg_hit && !bus.cfg_valid;

    // circular search starting just after the last serviced slot;
    // index arithmetic wraps naturally at IDX_W bits
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        found     = 1'b0;
        found_idx = last_idx_q;
        for (int i = 1; i <= NUM_SLOTS; i++) begin
            cand = last_idx_q + IDX_W'(i);
            if (!found && valid_q[cand]) begin
                found     = 1'b1;
                found_idx = cand;
            end
        end
    end

    assign nx13 = {1'b0, bus.x0_int};
    assign ny13 = {2'b00, bus.y0_int};
    assign oob  = (nx13 < X_LO) || (nx13 > X_HI) ||
                  (ny13 < Y_LO) || (ny13 > Y_HI);

    assign miss_inc    = miss_q[cur_idx_q] + MW'(1);
    assign miss_retire = (miss_inc == MW'(MAX_MISS));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (vsync_rise) state_d = S_SELECT;
            S_SELECT: state_d = found ? S_LOAD : S_IDLE;
            S_LOAD:   state_d = S_ARM;
            S_ARM: begin
                if (cfg_kill)                  state_d = S_IDLE;
                else if (!bus.center_vsync_in) state_d = S_TRACK;
            end
            S_TRACK: begin
                if (cfg_kill)                       state_d = S_IDLE;
                else if (bus.updated_in_this_frame) state_d = S_WB;
                else if (vsync_rise)                state_d = S_MISS;
            end
            S_WB:     state_d = S_IDLE;
            // the rise that caused the miss already opens the next frame
            S_MISS:   state_d = S_SELECT;
            default:  state_d = S_IDLE;
        endcase
    end

    assign bus.reset_position = (state_q == S_LOAD);
    assign bus.enable         = (state_q == S_ARM) || (state_q == S_TRACK);
    assign bus.frame_done     = (state_q == S_WB);
    assign bus.slot_lost      = !cfg_hit &&
                                (((state_q == S_WB) && oob) ||
                                 ((state_q == S_MISS) && miss_retire));
    assign bus.lost_idx       = bus.slot_lost ? cur_idx_q : '0;
    assign bus.cur_idx        = cur_idx_q;
    assign bus.track_active   = track_active_q;
    assign bus.set_x0 = (state_q == S_LOAD) ? x_q[cur_idx_q] : set_x0_q;
    assign bus.set_y0 = (state_q == S_LOAD) ? y_q[cur_idx_q] : set_y0_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            vsync_q        <= 1'b0;
            last_idx_q     <= IDX_W'(NUM_SLOTS - 1);
            cur_idx_q      <= '0;
            track_active_q <= 1'b0;
            set_x0_q       <= '0;
            set_y0_q       <= '0;
        end else begin
            state_q <= state_d;
            vsync_q <= bus.center_vsync_in;
            if (state_q == S_SELECT && found) begin
                cur_idx_q  <= found_idx;
                last_idx_q <= found_idx;
            end
            if (state_q == S_LOAD) begin
                set_x0_q       <= x_q[cur_idx_q];
                set_y0_q       <= y_q[cur_idx_q];
                track_active_q <= 1'b1;
            end else if (state_q == S_WB || state_q == S_MISS ||
                         state_d == S_IDLE) begin
                track_active_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                miss_q[i] <= '0;
            end
        end else begin
            if (state_q == S_WB && !cfg_hit) begin
                x_q[cur_idx_q]    <= bus.x0_int;
                y_q[cur_idx_q]    <= bus.y0_int;
                miss_q[cur_idx_q] <= '0;
                if (oob) valid_q[cur_idx_q] <= 1'b0;
            end
            if (state_q == S_MISS && !cfg_hit) begin
                if (miss_retire) begin
                    valid_q[cur_idx_q] <= 1'b0;
                    miss_q[cur_idx_q]  <= '0;
                end else begin
                    miss_q[cur_idx_q]  <= miss_inc;
                end
            end
            if (bus.cfg_we) begin
                x_q[bus.cfg_idx]     <= bus.cfg_x;
                y_q[bus.cfg_idx]     <= bus.cfg_y;
                valid_q[bus.cfg_idx] <= bus.cfg_valid;
                miss_q[bus.cfg_idx]  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_roi_track_scheduler.sv
// tb_roi_track_scheduler: frame-level reference model of the scheduler,
// directed scenarios followed by randomized frames and cfg writes.
module tb_roi_track_scheduler;
    localparam int NS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    roi_track_scheduler_if #(.IDX_W(3)) bus ();

    roi_track_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // observed pulses
    int rp_cnt = 0;
    int fd_cnt = 0;
    int rp_x, rp_y, rp_idx;
    int lostq[$];

    always @(negedge clk) begin
        if (bus.reset_position) begin
            rp_cnt++;
            rp_x   = int'(bus.set_x0);
            rp_y   = int'(bus.set_y0);
            rp_idx = int'(bus.cur_idx);
        end
        if (bus.frame_done) fd_cnt++;
        if (bus.slot_lost) lostq.push_back(int'(bus.lost_idx));
    end

    // reference slot table
    int mx[NS], my[NS], mm[NS];
    bit mv[NS];
    int mlast;
    int pend;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_oob(input int x, input int y);
        return (x < 13) || (x > 1268) || (y < 13) || (y > 708);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            mx[i] = 0; my[i] = 0; mm[i] = 0; mv[i] = 1'b0;
        end
        mlast = NS - 1;
        pend  = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        lostq.delete();
    endtask

    task automatic cfg_write(input int idx, input int x, input int y,
                             input bit v);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = 3'(idx);
        bus.cfg_x     = 12'(x);
        bus.cfg_y     = 11'(y);
        bus.cfg_valid = v;
        tick();
        bus.cfg_we    = 1'b0;
        mx[idx] = x; my[idx] = y; mv[idx] = v; mm[idx] = 0;
        if (idx == pend && !v) pend = -1;
    endtask

    // one frame: vsync pulse, active period with optional tracker update
    task automatic frame(input bit upd, input int nx, input int ny,
                         input bit cfg_wb, input int cx, input int cy);
        int sel;
        int rp0;
        int fd0;
        int explost[$];
        rp0 = rp_cnt;
        fd0 = fd_cnt;
        if (pend >= 0) begin
            mm[pend]++;
            if (mm[pend] == 3) begin
                mv[pend] = 1'b0;
                mm[pend] = 0;
                explost.push_back(pend);
            end
            pend = -1;
        end
        sel = -1;
        for (int i = 1; i <= NS; i++) begin
            int j;
            j = (mlast + i) % NS;
            if (sel < 0 && mv[j]) sel = j;
        end
        if (sel >= 0) mlast = sel;

        bus.center_vsync_in = 1'b1;
        repeat (6) tick();
        bus.center_vsync_in = 1'b0;
        repeat (4) tick();

        chk("load_count", rp_cnt - rp0, int'(sel >= 0));
        if (sel >= 0) begin
            chk("load_idx", rp_idx, sel);
            chk("load_x", rp_x, mx[sel]);
            chk("load_y", rp_y, my[sel]);
        end
        chk("track_active", int'(bus.track_active), int'(sel >= 0));
        chk("enable_mid", int'(bus.enable), int'(sel >= 0));

        if (upd) begin
            bus.x0_int = 12'(nx);
            bus.y0_int = 11'(ny);
            bus.updated_in_this_frame = 1'b1;
            tick();
            bus.updated_in_this_frame = 1'b0;
            if (cfg_wb && sel >= 0) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_idx   = 3'(sel);
                bus.cfg_x     = 12'(cx);
                bus.cfg_y     = 11'(cy);
                bus.cfg_valid = 1'b1;
                tick();
                bus.cfg_we    = 1'b0;
            end
        end
        repeat (4) tick();

        if (sel >= 0 && upd) begin
            if (cfg_wb) begin
                mx[sel] = cx; my[sel] = cy; mv[sel] = 1'b1;
            end else begin
                mx[sel] = nx; my[sel] = ny;
                if (is_oob(nx, ny)) begin
                    mv[sel] = 1'b0;
                    explost.push_back(sel);
                end
            end
            mm[sel] = 0;
        end else if (sel >= 0) begin
            pend = sel;
        end

        chk("frame_done", fd_cnt - fd0, int'(sel >= 0 && upd));
        chk("enable_end", int'(bus.enable), int'(sel >= 0 && !upd));
        chk("lost_count", lostq.size(), explost.size());
        while (explost.size() > 0 && lostq.size() > 0)
            chk("lost_idx", lostq.pop_front(), explost.pop_front());
        lostq.delete();
        repeat (2) tick();
    endtask

    int xe[4] = '{12, 13, 1268, 1269};
    int ye[4] = '{12, 13, 708, 709};

    initial begin
        int nx, ny;
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_x = '0;
        bus.cfg_y = '0;
        bus.cfg_valid = 1'b0;
        bus.center_vsync_in = 1'b0;
        bus.updated_in_this_frame = 1'b0;
        bus.x0_int = '0;
        bus.y0_int = '0;
        model_reset();

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_enable", int'(bus.enable), 0);
        chk("rst_track_active", int'(bus.track_active), 0);
        chk("rst_reset_position", int'(bus.reset_position), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        chk("rst_slot_lost", int'(bus.slot_lost), 0);
        chk("rst_cur_idx", int'(bus.cur_idx), 0);
        chk("rst_set_x0", int'(bus.set_x0), 0);
        rst = 1'b0;
        tick();

        // basic load / writeback, then reload of refined position
        cfg_write(2, 700, 500, 1'b1);
        frame(1'b1, 705, 498, 1'b0, 0, 0);
        frame(1'b1, 706, 499, 1'b0, 0, 0);

        // round robin with wrap: 0, 3, 7, 0
        do_reset();
        cfg_write(0, 100, 100, 1'b1);
        cfg_write(3, 300, 300, 1'b1);
        cfg_write(7, 700, 600, 1'b1);
        repeat (4) frame(1'b1, 400, 400, 1'b0, 0, 0);

        // repeated misses retire a slot, then nothing to service
        do_reset();
        cfg_write(1, 640, 360, 1'b1);
        repeat (5) frame(1'b0, 0, 0, 1'b0, 0, 0);

        // border: x=12 lost, x=13 kept
        do_reset();
        cfg_write(5, 100, 100, 1'b1);
        frame(1'b1, 12, 300, 1'b0, 0, 0);
        frame(1'b1, 0, 0, 1'b0, 0, 0);
        cfg_write(5, 100, 100, 1'b1);
        frame(1'b1, 13, 300, 1'b0, 0, 0);

        // cfg write coincident with writeback wins, loss suppressed
        frame(1'b1, 5, 300, 1'b1, 100, 100);
        frame(1'b0, 0, 0, 1'b0, 0, 0);
        frame(1'b1, 200, 200, 1'b0, 0, 0);

        // reset while tracking
        do_reset();
        cfg_write(4, 500, 400, 1'b1);
        bus.center_vsync_in = 1'b1;
        repeat (6) tick();
        bus.center_vsync_in = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_trk_enable", int'(bus.enable), 0);
        chk("rst_trk_active", int'(bus.track_active), 0);
        rst = 1'b0;
        model_reset();
        lostq.delete();
        tick();
        frame(1'b1, 500, 400, 1'b0, 0, 0);

        // randomized frames
        do_reset();
        for (int i = 0; i < 4; i++)
            cfg_write(int'($urandom_range(0, NS - 1)),
                      int'($urandom_range(13, 1268)),
                      int'($urandom_range(13, 708)), 1'b1);
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 4) == 0) nx = xe[$urandom_range(0, 3)];
            else nx = int'($urandom_range(13, 1268));
            if ($urandom_range(0, 4) == 0) ny = ye[$urandom_range(0, 3)];
            else ny = int'($urandom_range(13, 708));
            frame($urandom_range(0, 3) != 0, nx, ny,
                  $urandom_range(0, 7) == 0,
                  int'($urandom_range(13, 1268)),
                  int'($urandom_range(13, 708)));
            repeat ($urandom_range(0, 2))
                cfg_write(int'($urandom_range(0, NS - 1)),
                          int'($urandom_range(13, 1268)),
                          int'($urandom_range(13, 708)),
                          $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
